// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared ALU op codes, dispatch masks and controller state encoding
package alu_issue_ctrl_pkg;

  localparam int OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_ADD    = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB    = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_AND    = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_OR     = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_XOR    = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_SLL    = 4'd5;
  localparam logic [OP_WIDTH-1:0] OP_SRL    = 4'd6;
  localparam logic [OP_WIDTH-1:0] OP_MUL    = 4'd7;
  localparam logic [OP_WIDTH-1:0] OP_MULH   = 4'd9;
  localparam logic [OP_WIDTH-1:0] OP_MULHU  = 4'd10;
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = 4'd11;

  localparam logic [15:0] SYNC_OP_MASK_DEFAULT  = 16'h0E80;
  localparam logic [15:0] ASYNC_OP_MASK_DEFAULT = 16'h007F;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_EXEC_ASYNC = 3'd1;
  localparam logic [2:0] ST_ISSUE      = 3'd2;
  localparam logic [2:0] ST_WAIT       = 3'd3;
  localparam logic [2:0] ST_RESP       = 3'd4;

endpackage

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU operand/trigger initiator between the execute request stream and the ALU
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int                    OP_WIDTH       = alu_issue_ctrl_pkg::OP_WIDTH,
  parameter logic [2**OP_WIDTH-1:0] SYNC_OP_MASK  = SYNC_OP_MASK_DEFAULT,
  parameter logic [2**OP_WIDTH-1:0] ASYNC_OP_MASK = ASYNC_OP_MASK_DEFAULT,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_WIDTH-1:0] req_op,
  input  logic [31:0]         req_a,
  input  logic [31:0]         req_b,
  input  logic [4:0]          req_rd,
  output logic [OP_WIDTH-1:0] alu_operation,
  output logic [31:0]         alu_in1,
  output logic [31:0]         alu_in2,
  output logic                alu_trigger_sync,
  input  logic                alu_busy,
  input  logic                alu_result_ready,
  input  logic [31:0]         alu_out_sync,
  input  logic [31:0]         alu_out_async,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_data,
  output logic [4:0]          resp_rd,
  output logic                resp_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]          state_q, state_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [4:0]          rd_q, rd_d;
  logic [31:0]         data_q, data_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                trigger;
  logic                timeout;

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    trigger = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          a_d    = req_a;
          b_d    = req_b;
          rd_d   = req_rd;
          data_d = '0;
          err_d  = 1'b0;
          cnt_d  = '0;
          if (ASYNC_OP_MASK[req_op]) begin
            state_d = ST_EXEC_ASYNC;
          end else if (SYNC_OP_MASK[req_op]) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
        end
      end
      ST_EXEC_ASYNC: begin
        data_d  = alu_out_async;
        state_d = ST_RESP;
      end
      // Timeout wins over a late trigger so an abandoned op never starts the ALU.
      ST_ISSUE: begin
        if (timeout) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!alu_busy) begin
            trigger = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (alu_result_ready) begin
          data_d  = alu_out_sync;
          state_d = ST_RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready        = (state_q == ST_IDLE);
  assign resp_valid       = (state_q == ST_RESP);
  assign resp_data        = data_q;
  assign resp_rd          = rd_q;
  assign resp_error       = err_q;
  assign alu_operation    = op_q;
  assign alu_in1          = a_q;
  assign alu_in2          = b_q;
  assign alu_trigger_sync = trigger;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_rd = '0;
  logic [3:0]  alu_operation;
  logic [31:0] alu_in1, alu_in2;
  logic        alu_trigger_sync;
  logic        alu_busy, alu_result_ready;
  logic [31:0] alu_out_sync, alu_out_async;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_error;

  always #5 clock = ~clock;

  alu_issue_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .alu_operation(alu_operation), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_trigger_sync(alu_trigger_sync), .alu_busy(alu_busy),
    .alu_result_ready(alu_result_ready), .alu_out_sync(alu_out_sync),
    .alu_out_async(alu_out_async),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_error(resp_error)
  );

  function automatic logic [31:0] alu_math(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = '0;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << b[4:0];
      6: return a >> b[4:0];
      7: return a * b;
      9: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      10: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      11: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [32:0] expect_resp(input int op, input logic [31:0] a, input logic [31:0] b, input bit tmo);
    bit legal;
    legal = (op <= 6) || (op == 7) || (op == 9) || (op == 10) || (op == 11);
    if (!legal || tmo) return {1'b1, 32'h0};
    return {1'b0, alu_math(op, a, b)};
  endfunction

  // Behavioural ALU: combinational path for codes 0-6, multi-cycle path started by the trigger.
  logic        m_busy = 1'b0, m_rdy = 1'b0;
  logic [31:0] m_res = '0;
  int          m_cnt = 0;
  int          lat_cfg = 3;
  logic        hang = 1'b0;
  logic        force_busy = 1'b0;

  always_comb begin
    alu_out_async = (alu_operation <= 4'd6) ? alu_math(int'(alu_operation), alu_in1, alu_in2) : 32'hDEAD_BEEF;
  end
  assign alu_busy         = m_busy | force_busy;
  assign alu_result_ready = m_rdy;
  assign alu_out_sync     = m_res;

  always @(posedge clock) begin
    if (alu_trigger_sync) begin
      m_res <= alu_math(int'(alu_operation), alu_in1, alu_in2);
      m_rdy <= 1'b0;
      if (hang) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
      end else if (alu_in1 == 32'h0 || alu_in2 == 32'h0) begin
        m_rdy  <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_busy <= 1'b1;
        m_cnt  <= lat_cfg;
      end
    end else if (m_busy && m_cnt > 0) begin
      if (m_cnt == 1) begin
        m_rdy  <= 1'b1;
        m_busy <= 1'b0;
      end
      m_cnt <= m_cnt - 1;
    end else if (!hang && m_busy) begin
      m_busy <= 1'b0;
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int ncyc = 0, acc_cyc = -1, trig_first = -1, trig_n = 0, resp_first = -1, rdy_first = -1;
  bit rand_rr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: event capture, protocol checks and scoreboard pop on every response transfer.
  initial begin
    logic        prev_trig;
    logic        prev_stall;
    logic [37:0] prev_out;
    exp_t        e;
    prev_trig = 1'b0;
    prev_stall = 1'b0;
    prev_out = '0;
    forever begin
      @(negedge clock);
      ncyc++;
      if (reset) begin
        prev_trig = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (req_valid && req_ready) acc_cyc = ncyc;
        if (alu_trigger_sync) begin
          chk("trigger_not_back_to_back", {63'b0, prev_trig}, 64'd0);
          trig_n++;
          if (trig_first < 0) trig_first = ncyc;
        end
        prev_trig = alu_trigger_sync;
        if (alu_result_ready && trig_first >= 0 && ncyc > trig_first && rdy_first < 0) rdy_first = ncyc;
        if (prev_stall) begin
          chk("resp_held_valid", {63'b0, resp_valid}, 64'd1);
          chk("resp_held_stable", {26'b0, resp_data, resp_rd, resp_error}, {26'b0, prev_out});
        end
        if (resp_valid && resp_first < 0) resp_first = ncyc;
        if (resp_valid && resp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", {63'b0, resp_valid}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_data", {32'b0, resp_data}, {32'b0, e.data});
            chk("resp_rd", {59'b0, resp_rd}, {59'b0, e.rd});
            chk("resp_error", {63'b0, resp_error}, {63'b0, e.err});
          end
        end
        prev_stall = resp_valid && !resp_ready;
        prev_out = {resp_data, resp_rd, resp_error};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_rr) resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Drive one request and push its expectation; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input bit tmo);
    exp_t e;
    logic [32:0] r;
    r = expect_resp(int'(op), a, b, tmo);
    e.data = r[31:0];
    e.rd   = rd;
    e.err  = r[32];
    acc_cyc = -1; trig_first = -1; trig_n = 0; resp_first = -1; rdy_first = -1;
    req_op = op; req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
    exp_q.push_back(e);
    for (int i = 0; i < 400 && acc_cyc < 0; i++) @(posedge clock);
    #1;
    if (acc_cyc < 0) chk("accept_timeout", 64'd0, 64'd1);
    req_valid = 1'b0;
    req_a = $urandom;
    req_b = $urandom;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    if (exp_q.size() != 0) chk("resp_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("rst_resp_error", {63'b0, resp_error}, 64'd0);
    chk("rst_resp_data", {32'b0, resp_data}, 64'd0);
    chk("rst_resp_rd", {59'b0, resp_rd}, 64'd0);
    chk("rst_trigger", {63'b0, alu_trigger_sync}, 64'd0);
    chk("rst_alu_op", {60'b0, alu_operation}, 64'd0);
    chk("rst_alu_in", {alu_in1, alu_in2}, 64'd0);
    @(posedge clock);
    #1;

    send(4'd0, 32'd5, 32'd3, 5'd3, 1'b0);
    wait_empty();
    chk("add_latency", 64'(resp_first - acc_cyc), 64'd2);
    chk("add_no_trigger", 64'(trig_n), 64'd0);

    lat_cfg = 3;
    send(4'd7, 32'd7, 32'd6, 5'd17, 1'b0);
    wait_empty();
    chk("mul_one_trigger", 64'(trig_n), 64'd1);
    chk("mul_trigger_cycle", 64'(trig_first - acc_cyc), 64'd1);
    chk("mul_resp_after_ready", 64'(resp_first - rdy_first), 64'd1);

    send(4'd7, 32'd123, 32'd0, 5'd4, 1'b0);
    wait_empty();
    chk("mul_zero_latency", 64'(resp_first - acc_cyc), 64'd3);
    chk("mul_zero_trigger", 64'(trig_n), 64'd1);

    force_busy = 1'b1;
    lat_cfg = 2;
    send(4'd7, 32'h1234, 32'h5678, 5'd9, 1'b0);
    repeat (10) @(posedge clock);
    #1 force_busy = 1'b0;
    wait_empty();
    chk("busy_trigger_cycle", 64'(trig_first - acc_cyc), 64'd11);
    chk("busy_one_trigger", 64'(trig_n), 64'd1);

    send(4'd8, $urandom, $urandom, 5'd2, 1'b0);
    wait_empty();
    chk("illegal_no_trigger", 64'(trig_n), 64'd0);
    chk("illegal_latency", 64'(resp_first - acc_cyc), 64'd1);

    hang = 1'b1;
    send(4'd10, 32'd3, 32'd4, 5'd12, 1'b1);
    wait_empty();
    chk("timeout_latency", 64'(resp_first - acc_cyc), 64'd65);
    chk("timeout_one_trigger", 64'(trig_n), 64'd1);

    // Free the stuck ALU, start a sync op, then reset it while it sits in WAIT.
    hang = 1'b0;
    repeat (2) @(posedge clock);
    #1 hang = 1'b1;
    send(4'd11, 32'hFFFF_0000, 32'd77, 5'd6, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clock);
    chk("midrst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("midrst_trigger", {63'b0, alu_trigger_sync}, 64'd0);
    chk("midrst_req_ready", {63'b0, req_ready}, 64'd1);
    @(posedge clock);
    #1;
    send(4'd7, 32'd5, 32'd5, 5'd1, 1'b1);
    wait_empty();
    chk("stuck_busy_no_trigger", 64'(trig_n), 64'd0);
    chk("stuck_busy_latency", 64'(resp_first - acc_cyc), 64'd65);
    hang = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    resp_ready = 1'b0;
    send(4'd4, 32'hA5A5_0F0F, 32'h0FF0_1234, 5'd20, 1'b0);
    for (int i = 0; i < 20 && resp_first < 0; i++) @(posedge clock);
    repeat (5) begin
      @(negedge clock);
      chk("stall_req_ready", {63'b0, req_ready}, 64'd0);
    end
    @(posedge clock);
    #1 resp_ready = 1'b1;
    wait_empty();

    rand_rr = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      lat_cfg = $urandom_range(1, 5);
      send(4'($urandom_range(0, 15)), ra, rb, 5'($urandom), 1'b0);
    end
    wait_empty();
    rand_rr = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operand/trigger handshake. Sits between the execute-stage request stream and the ALU.
- Accepts one operation at a time over valid/ready and presents registered operands to the ALU.
- Async ops: captures the ALU's combinational result. Sync ops: pulses the trigger, waits on result_ready, captures the synchronous result.
- Returns result plus destination register over valid/ready, with an error flag for illegal ops and timeouts.

Parameters:
- OP_WIDTH, 4, ALU operation code width (shared constant).
- SYNC_OP_MASK, 16'h0E80, bit k set means op code k is dispatched on the multi-cycle path. Default covers MUL(7), MULH(9), MULHU(10), MULHSU(11).
- ASYNC_OP_MASK, 16'h007F, bit k set means op code k is a combinational op (codes 0–6).
- TIMEOUT_CYCLES, 64, maximum cycles spent in ISSUE+WAIT before aborting with an error.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  OP_WIDTH  ALU operation code
- req_a  in  32  operand 1
- req_b  in  32  operand 2
- req_rd  in  5  destination register tag, passed through unchanged
- alu_operation  out  OP_WIDTH  to ALU operation
- alu_in1  out  32  to ALU in1
- alu_in2  out  32  to ALU in2
- alu_trigger_sync  out  1  one-cycle start pulse
- alu_busy  in  1  from ALU busy
- alu_result_ready  in  1  from ALU result_ready
- alu_out_sync  in  32  from ALU out_sync
- alu_out_async  in  32  from ALU out_async
- resp_valid  out  1  result present
- resp_ready  in  1  consumer accepts result
- resp_data  out  32  result
- resp_rd  out  5  destination register tag
- resp_error  out  1  illegal op or timeout; resp_data is 0 when set

Behaviour:
- States: IDLE, EXEC_ASYNC, ISSUE, WAIT, RESP.
- req_ready = (state==IDLE). A request is accepted when req_valid && req_ready.
- On accept, register op, a, b and rd. alu_operation, alu_in1 and alu_in2 are driven only from these registers, so they are stable for the whole transaction.
- Routing on accept:
  - op in ASYNC_OP_MASK: go to EXEC_ASYNC.
  - op in SYNC_OP_MASK: go to ISSUE and clear the timeout counter.
  - otherwise: go to RESP with resp_error=1, resp_data=0.
- EXEC_ASYNC (one cycle): resp_data <= alu_out_async; go to RESP.
- ISSUE:
  - if !alu_busy: alu_trigger_sync=1 for exactly this cycle, then go to WAIT.
  - else: hold, trigger stays 0.
- WAIT:
  - alu_result_ready is sampled only in this state. Stale high from a previous op cannot occur because the ALU clears it on the trigger edge.
  - on alu_result_ready=1: resp_data <= alu_out_sync; go to RESP.
  - A zero-operand multiply completes on the first WAIT cycle.
- Timeout: counter increments every cycle in ISSUE or WAIT. On reaching TIMEOUT_CYCLES-1, go to RESP with resp_error=1, resp_data=0. This bounds ops the ALU never completes, e.g. divide codes if enabled in the mask.
- RESP: resp_valid=1, with resp_data, resp_rd and resp_error held stable until resp_ready. Transfer occurs when resp_valid && resp_ready; return to IDLE on that edge. No new request is accepted in the same cycle as the response transfer.
- Latency:
  - async: accept edge N; resp_valid first high in cycle N+2.
  - sync: trigger in cycle N+1 if ALU idle; resp_valid high the cycle after result_ready is seen.
- alu_trigger_sync is never high outside ISSUE and never high for two consecutive cycles.
- Reset values: state=IDLE, req_ready=1 after the reset cycle, resp_valid=0, resp_error=0, resp_data=0, resp_rd=0, alu_trigger_sync=0, alu_operation=0, alu_in1=0, alu_in2=0, counter=0.
- Reset mid-operation: abandon the transaction, no response is produced. The ALU has no reset and may stay busy; the next sync op waits in ISSUE, bounded by the timeout.

Decomposition:
- Shared package: ALU op code constants, OP_WIDTH, default masks, and controller state encoding (3 bits).
- No sub-module required. The timeout counter stays inline.

Test Plan:
- ADD: a=0x0000_0005, b=0x0000_0003, with ALU model → resp_data=0x8, resp_error=0, resp_valid at accept+2, trigger never asserted.
- MUL: a=7, b=6 → exactly one trigger pulse one cycle after accept; resp_data=42 the cycle after result_ready; resp_rd echoes req_rd=5'd17.
- MUL with b=0 → result_ready on first WAIT cycle; resp_data=0; total latency accept+3.
- alu_busy held high for 10 cycles at ISSUE → trigger delayed until busy falls; then normal completion.
- Op 8 (illegal) → resp_error=1, resp_data=0, no trigger. ALU model never raising result_ready on MULHU → resp_error=1 after 64 cycles.
- resp_ready low for 5 cycles → outputs stable, req_ready=0. Reset asserted during WAIT → next cycle resp_valid=0, trigger=0, state IDLE.
